rev_alu_seq: RTL and testbench

Parametrised, clocked successor to the 8-bit combinational reversible ALU. It accepts one operation at a time over a valid/ready input handshake and registers the result and flags into a held output slot with its own valid/ready handshake. It adds SUB, add-with-carry from a stored carry flag, and an optional iterative shift-add multiplier. It sits between the operand-sequencing logic and the result writeback path.

---
 rtl/rev_alu_seq.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_rev_alu_seq.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rev_alu_seq.sv
// ---------------------------------------------------------------------------
// rev_alu_seq
//
// Clocked, parametrised reversible ALU. It accepts one operation at a time
// over a valid/ready input handshake. It writes the result and flags into a
// single held output slot, which has its own valid/ready handshake.
//
// Optional feature macro: REVALU_MUL_EN
//   defined   : sel=011 runs an unsigned shift-add multiply over WIDTH cycles
//               (RUN state, busy output).
//   undefined : sel=011 completes in one cycle with an all-zero result
//               (zero=1). No FSM and no multiplier datapath are built.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   in_valid/in_ready input handshake; transfer when both are high
//   a, b [WIDTH]      operands, captured on the accept edge
//   sel [3]           000 ADD, 001 SUB, 010 ADC, 011 MUL,
//                     100 AND, 101 OR, 110 XOR, 111 NOT A
//   out_valid/out_ready output slot handshake; consume when both are high
//   result [WIDTH]    result, or the low half of the product
//   result_hi [WIDTH] high half of the product; 0 for other ops
//   cout, zero, ovf   carry (SUB: 1 = no borrow), result==0, signed overflow
//   busy              multiply in progress; this is also the FSM state
//                     (1 = RUN)
//
// Handshake rule (both sides): a beat transfers on a rising edge where
// valid && ready. valid must not depend on ready. The slot holds
// result/flags stable while out_valid && !out_ready. in_ready depends
// combinationally on out_ready, so a full slot can be drained and refilled
// on the same edge.
// ---------------------------------------------------------------------------
module rev_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             cout,
  output logic             zero,
  output logic             ovf,
  output logic             busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADC = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  // Output slot and carry flag.
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             cout_q,      cout_d;
  logic             zero_q,      zero_d;
  logic             ovf_q,       ovf_d;
  logic             carry_q,     carry_d;

  logic accept;
  logic consume;
  logic alu_write;

  assign accept  = in_valid && in_ready;
  assign consume = out_valid_q && out_ready;

  // -------------------------------------------------------------------------
  // Single-cycle ALU. SUB is done as a + ~b + 1, so one adder serves
  // ADD, SUB and ADC. The overflow test uses the inverted b for SUB.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] b_eff;
  logic             alu_cin;
  logic [WIDTH:0]   alu_sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;
  logic             alu_ovf;
  logic             alu_arith;

  always_comb begin
    b_eff = (sel == OP_SUB) ? ~b : b;
    alu_cin = 1'b0;
    if (sel == OP_SUB) begin
      alu_cin = 1'b1;
    end else if (sel == OP_ADC) begin
      alu_cin = carry_q;
    end
    alu_sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, alu_cin};

    alu_res   = '0;
    alu_cout  = 1'b0;
    alu_ovf   = 1'b0;
    alu_arith = 1'b0;
    case (sel)
      OP_ADD, OP_SUB, OP_ADC: begin
        alu_res   = alu_sum[WIDTH-1:0];
        alu_cout  = alu_sum[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                    (alu_sum[WIDTH-1] != a[WIDTH-1]);
        alu_arith = 1'b1;
      end
      // Without the multiplier this is the one-cycle all-zero MUL result.
      // With it, this path is not taken for MUL.
      OP_MUL:  alu_res = '0;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOT:  alu_res = ~a;
      default: alu_res = '0;
    endcase
  end

`ifdef REVALU_MUL_EN
  // -------------------------------------------------------------------------
  // Multiplier FSM and shift-add datapath.
  // {prod_hi_q, prod_lo_q} starts as {0, multiplier}. Each RUN cycle adds
  // the multiplicand into the high half when the current LSB of the
  // multiplier is set, then shifts the whole pair right by one bit. After
  // WIDTH steps, the pair holds the full product.
  // -------------------------------------------------------------------------
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic [WIDTH-1:0] mcand_q,   mcand_d;
  logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
  logic [WIDTH-1:0] prod_lo_q, prod_lo_d;

  logic             mul_start;
  logic             mul_last;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx;
  logic [WIDTH-1:0] mul_lo_nx;

  assign mul_start = accept && (sel == OP_MUL);
  assign mul_last  = (state_q == S_RUN) && (cnt_q == CNT_LAST);
  assign alu_write = accept && !mul_start;

  always_comb begin
    mul_sum   = {1'b0, prod_hi_q} +
                (prod_lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    mul_hi_nx = mul_sum[WIDTH:1];
    mul_lo_nx = {mul_sum[0], prod_lo_q[WIDTH-1:1]};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (mul_start) state_d = S_RUN;
      S_RUN:   if (mul_last)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-derived outputs
  always_comb begin
    in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    busy     = (state_q == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      mcand_q   <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      prod_hi_q <= prod_hi_d;
      prod_lo_q <= prod_lo_d;
    end
  end
`else
  assign alu_write = accept;

  always_comb begin
    in_ready = !out_valid_q || out_ready;
    busy     = 1'b0;
  end
`endif

  // -------------------------------------------------------------------------
  // Slot / carry / multiplier next values
  // -------------------------------------------------------------------------
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    cout_d      = cout_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    carry_d     = carry_q;
`ifdef REVALU_MUL_EN
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    prod_hi_d   = prod_hi_q;
    prod_lo_d   = prod_lo_q;
`endif

    // A write on the same edge takes priority over the clear below.
    if (consume) begin
      out_valid_d = 1'b0;
    end

    if (alu_write) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      result_hi_d = '0;
      cout_d      = alu_cout;
      zero_d      = (alu_res == '0);
      ovf_d       = alu_ovf;
      if (alu_arith) begin
        carry_d = alu_cout;
      end
    end

`ifdef REVALU_MUL_EN
    // Operands are captured here, so the producer may change a/b at once.
    if (mul_start) begin
      cnt_d     = '0;
      mcand_d   = a;
      prod_hi_d = '0;
      prod_lo_d = b;
    end

    if (state_q == S_RUN) begin
      cnt_d     = cnt_q + CW'(1);
      prod_hi_d = mul_hi_nx;
      prod_lo_d = mul_lo_nx;
      // The slot is always empty here. MUL is only accepted when the slot
      // is empty or being drained, and nothing else writes it during RUN.
      if (mul_last) begin
        out_valid_d = 1'b1;
        result_d    = mul_lo_nx;
        result_hi_d = mul_hi_nx;
        cout_d      = |mul_hi_nx;
        zero_d      = (mul_lo_nx == '0);
        ovf_d       = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      cout_q      <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      cout_q      <= cout_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      carry_q     <= carry_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_rev_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_rev_alu_seq
//
// Self-checking bench for rev_alu_seq at WIDTH=8. It applies a table of
// directed vectors, hand-written handshake/reset sequences, and random
// operations. The random operations are checked against an arithmetic
// reference model. It works with REVALU_MUL_EN either defined or not.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rev_alu_seq;

  localparam int W = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADC = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

`ifdef REVALU_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   sel = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         cout;
  logic         zero;
  logic         ovf;
  logic         busy;

  rev_alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .cout      (cout),
    .zero      (zero),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic carry_m;
  logic [2*W+2:0] exp_q[$];   // {res, hi, cout, zero, ovf}

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         c;
    logic         z;
    logic         o;
  } exp_t;

  typedef struct {
    logic [2:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         c;
    logic         z;
    logic         o;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [2:0] s, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic c,
                                 output logic c_new);
    exp_t r;
    int m, xi, yi, sx, sy, full, sr, ci;
    m  = 1 << W;
    xi = int'(x);
    yi = int'(y);
    ci = c ? 1 : 0;
    sx = (xi >= m/2) ? xi - m : xi;
    sy = (yi >= m/2) ? yi - m : yi;
    r.res = '0; r.hi = '0; r.c = 1'b0; r.o = 1'b0;
    c_new = c;
    case (s)
      OP_ADD, OP_ADC: begin
        full  = xi + yi + ((s == OP_ADC) ? ci : 0);
        sr    = sx + sy + ((s == OP_ADC) ? ci : 0);
        r.res = W'(full % m);
        r.c   = (full >= m);
        r.o   = (sr < -(m/2)) || (sr >= m/2);
        c_new = r.c;
      end
      OP_SUB: begin
        full  = xi - yi;
        sr    = sx - sy;
        r.res = W'((full + m) % m);
        r.c   = (xi >= yi);
        r.o   = (sr < -(m/2)) || (sr >= m/2);
        c_new = r.c;
      end
      OP_MUL: begin
        if (MUL_ON) begin
          full  = xi * yi;
          r.res = W'(full % m);
          r.hi  = W'(full / m);
          r.c   = (full >= m);
        end
      end
      OP_AND:  r.res = x & y;
      OP_OR:   r.res = x | y;
      OP_XOR:  r.res = x ^ y;
      default: r.res = ~x;
    endcase
    r.z = (r.res == '0);
    return r;
  endfunction

  // ---------------- driver + checker for one operation ----------------
  task automatic run_op(input logic [2:0] s, input logic [W-1:0] x, input logic [W-1:0] y,
                        input exp_t e_in, input int stall, input string tag);
    int n, busy_n, nready_n, exp_lat;
    logic [2*W+2:0] e;
    exp_q.push_back({e_in.res, e_in.hi, e_in.c, e_in.z, e_in.o});
    exp_lat = (s == OP_MUL && MUL_ON) ? W + 1 : 1;

    @(negedge clk);
    sel = s; a = x; b = y; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);

    n = 0; busy_n = 0; nready_n = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) busy_n++;
      if (!in_ready) nready_n++;
    end while (!out_valid && n < 100);
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " busy cycles"}, 32'(busy_n), 32'(exp_lat - 1));
    check({tag, " in_ready low cycles"}, 32'(nready_n), 32'(exp_lat - 1));

    e = exp_q.pop_front();
    check({tag, " result"},    32'(result),    32'(e[2*W+2:W+3]));
    check({tag, " result_hi"}, 32'(result_hi), 32'(e[W+2:3]));
    check({tag, " cout"},      32'(cout),      32'(e[2]));
    check({tag, " zero"},      32'(zero),      32'(e[1]));
    check({tag, " ovf"},       32'(ovf),       32'(e[0]));

    // Optional backpressure: the slot must hold, and junk input is ignored.
    if (stall > 0) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      sel = 3'($urandom); a = W'($urandom); b = W'($urandom);
      repeat (stall) begin
        @(negedge clk);
        check({tag, " held slot"}, 32'({out_valid, in_ready, result, cout}),
              32'({1'b1, 1'b0, e[2*W+2:W+3], e[2]}));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] r, input logic [W-1:0] h,
                              input logic c, input logic z, input logic o);
    exp_t e;
    e.res = r; e.hi = h; e.c = c; e.z = z; e.o = o;
    return e;
  endfunction

  // ---------------- stimulus ----------------
  vec_t tbl[16];

  initial begin
    exp_t e;
    logic cn;
    logic [2:0] rs;
    logic [W-1:0] ra, rb;

    // Directed vectors, applied in order from reset (carry starts at 0).
    tbl[0]  = '{OP_ADD, 8'd13,  8'd3,   8'd16,  8'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{OP_ADD, 8'd127, 8'd1,   8'h80,  8'd0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{OP_ADD, 8'd255, 8'd1,   8'h00,  8'd0, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{OP_ADC, 8'd0,   8'd0,   8'h01,  8'd0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{OP_SUB, 8'd3,   8'd5,   8'hFE,  8'd0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{OP_SUB, 8'd5,   8'd3,   8'h02,  8'd0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{OP_AND, 8'hAA,  8'hCC,  8'h88,  8'd0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{OP_OR,  8'hAA,  8'hCC,  8'hEE,  8'd0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{OP_XOR, 8'hAA,  8'hCC,  8'h66,  8'd0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{OP_NOT, 8'hAA,  8'hCC,  8'h55,  8'd0, 1'b0, 1'b0, 1'b0};
    // carry is still 1 from SUB 5-3; logic ops leave it alone
    tbl[10] = '{OP_ADC, 8'd0,   8'd0,   8'h01,  8'd0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{OP_SUB, 8'h80,  8'd1,   8'h7F,  8'd0, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{OP_ADC, 8'h7F,  8'd0,   8'h80,  8'd0, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{OP_SUB, 8'd7,   8'd7,   8'h00,  8'd0, 1'b1, 1'b1, 1'b0};
`ifdef REVALU_MUL_EN
    tbl[14] = '{OP_MUL, 8'd200, 8'd3,   8'h58,  8'h02, 1'b1, 1'b0, 1'b0};
`else
    tbl[14] = '{OP_MUL, 8'd200, 8'd3,   8'h00,  8'h00, 1'b0, 1'b1, 1'b0};
`endif
    // MUL leaves carry=1 from SUB 7-7
    tbl[15] = '{OP_ADC, 8'd0,   8'd0,   8'h01,  8'd0, 1'b0, 1'b0, 1'b0};

    // ---- reset state ----
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", 32'({out_valid, result, result_hi, cout, zero, ovf, busy}), 32'd0);
    rst_n = 1'b1;
    #1;
    check("in_ready after reset", 32'(in_ready), 32'd1);

    // ---- directed table ----
    for (int i = 0; i < 16; i++) begin
      run_op(tbl[i].sel, tbl[i].a, tbl[i].b,
             mk(tbl[i].res, tbl[i].hi, tbl[i].c, tbl[i].z, tbl[i].o),
             0, $sformatf("vec%0d", i));
    end

    // ---- back-to-back: ADC sees the carry from the op one cycle earlier ----
    @(negedge clk);
    sel = OP_ADD; a = 8'd255; b = 8'd1; in_valid = 1'b1;
    check("b2b in_ready 1st", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("b2b first", 32'({out_valid, result, cout, in_ready}), 32'({1'b1, 8'h00, 1'b1, 1'b1}));
    sel = OP_ADC; a = 8'd0; b = 8'd0;
    @(negedge clk);
    check("b2b second", 32'({out_valid, result, cout}), 32'({1'b1, 8'h01, 1'b0}));
    in_valid = 1'b0;

    // ---- backpressure, then drain and refill on one edge ----
    @(negedge clk);
    out_ready = 1'b0;
    sel = OP_ADD; a = 8'd10; b = 8'd20; in_valid = 1'b1;
    check("bp in_ready empty", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("bp first result", 32'({out_valid, result, in_ready}), 32'({1'b1, 8'd30, 1'b0}));
    sel = OP_SUB; a = 8'd9; b = 8'd4;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp hold %0d", k), 32'({out_valid, result, in_ready}),
            32'({1'b1, 8'd30, 1'b0}));
    end
    out_ready = 1'b1;
    #1;
    check("bp in_ready on drain", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("bp refill", 32'({out_valid, result, cout}), 32'({1'b1, 8'd5, 1'b1}));
    in_valid = 1'b0;
    @(negedge clk);
    check("bp slot empty", 32'(out_valid), 32'd0);

    // ---- reset in the middle of an operation ----
    run_op(OP_ADD, 8'd255, 8'd1, mk(8'h00, 8'h00, 1'b1, 1'b1, 1'b0), 0, "pre-reset");
    @(negedge clk);
`ifdef REVALU_MUL_EN
    sel = OP_MUL; a = 8'd200; b = 8'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("mid-mul busy", 32'(busy), 32'd1);
`else
    out_ready = 1'b0;
    sel = OP_ADD; a = 8'd1; b = 8'd1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #2;
    check("slot full before reset", 32'(out_valid), 32'd1);
`endif
    rst_n = 1'b0;
    #1;
    check("async reset outputs", 32'({out_valid, result, result_hi, cout, zero, ovf, busy}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("in_ready after mid reset", 32'(in_ready), 32'd1);
    run_op(OP_ADC, 8'd1, 8'd1, mk(8'd2, 8'd0, 1'b0, 1'b0, 1'b0), 0, "adc after reset");

    // ---- random operations against the model ----
    carry_m = 1'b0;
    for (int i = 0; i < 200; i++) begin
      rs = 3'($urandom_range(0, 7));
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) ra = 8'hFF;
      if ($urandom_range(0, 9) == 0) rb = 8'h80;
      e = model(rs, ra, rb, carry_m, cn);
      run_op(rs, ra, rb, e, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
             $sformatf("rnd%0d sel=%0d a=%0h b=%0h", i, rs, ra, rb));
      carry_m = cn;
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
